// File: rtl/load_store_unit.sv
// load_store_unit: core-side initiator for a word-indexed data memory.
// Accepts one RV32I load/store (LB/LH/LW/LBU/LHU/SB/SH/SW) at a time.
// Sub-word stores are performed as read-modify-write. Misaligned,
// out-of-range and illegal requests get an error response without any
// memory access.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only in IDLE, not in reset)
//   req_we, req_funct3       store flag and RV32I width/sign code
//   req_addr, req_wdata      byte address and store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_err     extended load data (0 for stores/errors), reject flag
//   mem_addr, mem_wdata      word index and write word to the memory
//   mem_we                   memory write enable
//   mem_rdata                combinational read data for mem_addr
module load_store_unit #(
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next_state;

  // Request latched at acceptance
  logic            r_we;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic [AW-1:0]   r_idx;
  logic [DW-1:0]   r_wdata;

  // Output registers
  logic            r_resp_valid;
  logic [DW-1:0]   r_resp_rdata;
  logic            r_resp_err;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic            r_mem_we;

  // Next-state values for the output registers
  logic            w_accept;
  logic            w_resp_valid;
  logic [DW-1:0]   w_resp_rdata;
  logic            w_resp_err;
  logic [AW-1:0]   w_mem_addr;
  logic [DW-1:0]   w_mem_wdata;
  logic            w_mem_we;

  logic [AW-1:0]   w_req_idx;
  logic            w_misalign;
  logic            w_oob;
  logic            w_bad_f3;
  logic            w_req_err;

  // Select lane from a memory word and sign/zero extend it for the load width
  function automatic logic [DW-1:0] f_load_ext(input logic [DW-1:0] word,
                                               input logic [1:0]    off,
                                               input logic [2:0]    f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  f_load_ext = {{24{b[7]}}, b};
      3'b001:  f_load_ext = {{16{h[15]}}, h};
      3'b100:  f_load_ext = {24'd0, b};
      3'b101:  f_load_ext = {16'd0, h};
      default: f_load_ext = word;
    endcase
  endfunction

  // Replace the addressed byte/half of the old word with store data
  function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] wd,
                                            input logic [1:0]    off,
                                            input logic [2:0]    f3);
    logic [DW-1:0] w;
    w = old;
    if (f3 == 3'b000) begin
      case (off)
        2'd0:    w[7:0]   = wd[7:0];
        2'd1:    w[15:8]  = wd[7:0];
        2'd2:    w[23:16] = wd[7:0];
        default: w[31:24] = wd[7:0];
      endcase
    end else if (f3 == 3'b001) begin
      if (off[1]) w[31:16] = wd[15:0];
      else        w[15:0]  = wd[15:0];
    end else begin
      w = wd;
    end
    f_merge = w;
  endfunction

  // Request legality, evaluated on the live request at acceptance
  always_comb begin
    w_req_idx  = {2'b00, req_addr[31:2]};
    w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_oob      = (w_req_idx >= AW'(MEM_DEPTH));
    w_bad_f3   = req_we ? (req_funct3 > 3'b010)
                        : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    w_req_err  = w_misalign || w_oob || w_bad_f3;
  end

  // Next state and next output register values
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_resp_valid = 1'b0;
    w_resp_rdata = '0;
    w_resp_err   = 1'b0;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;
    w_mem_we     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept   = 1'b1;
          w_mem_addr = w_req_idx;
          if (w_req_err) begin
            w_next_state = S_RESP;
            w_resp_valid = 1'b1;
            w_resp_err   = 1'b1;
          end else if (req_we && (req_funct3 == 3'b010)) begin
            w_next_state = S_WR;
            w_mem_we     = 1'b1;
            w_mem_wdata  = req_wdata;
          end else begin
            w_next_state = S_RD;
          end
        end
      end
      S_RD: begin
        // Read word is consumed here: extended for loads, merged for sub-word stores
        w_mem_addr = r_idx;
        if (r_we) begin
          w_next_state = S_WR;
          w_mem_we     = 1'b1;
          w_mem_wdata  = f_merge(mem_rdata, r_wdata, r_off, r_funct3);
        end else begin
          w_next_state = S_RESP;
          w_resp_valid = 1'b1;
          w_resp_rdata = f_load_ext(mem_rdata, r_off, r_funct3);
        end
      end
      S_WR: begin
        w_next_state = S_RESP;
        w_mem_addr   = r_idx;
        w_resp_valid = 1'b1;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State, request latches and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_we         <= 1'b0;
      r_funct3     <= '0;
      r_off        <= '0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_resp_valid <= w_resp_valid;
      r_resp_rdata <= w_resp_rdata;
      r_resp_err   <= w_resp_err;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_mem_we     <= w_mem_we;
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_off    <= req_addr[1:0];
        r_idx    <= w_req_idx;
        r_wdata  <= req_wdata;
      end
    end
  end

  // Reset must block an in-flight write immediately, not at the next edge
  assign mem_we     = r_mem_we && !rst;
  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random requests checked
// against a behavioural model (byte-address arithmetic over a shadow memory).
module tb_load_store_unit;

  localparam int unsigned DEPTH = 1024;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on rising edge
  assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[9:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_we && (mem_addr < DEPTH)) mem[mem_addr[9:0]] = mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: is the request rejected?
  function automatic bit m_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    sz = 1 << f3[1:0];
    if ((a % sz) != 0) return 1'b1;
    if ((a >> 2) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  // Model: load result from a word given byte offset and width/sign code
  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
    int sz;
    int sh;
    logic [31:0] mask;
    logic [31:0] v;
    sz   = 1 << f3[1:0];
    sh   = 8 * int'(off);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v    = (w >> sh) & mask;
    if (!f3[2] && (sz < 4) && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  // Model: memory word after a store of the given width at offset
  function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [2:0] f3, input logic [1:0] off);
    int sz;
    int sh;
    logic [31:0] mask;
    sz   = 1 << f3[1:0];
    sh   = 8 * int'(off);
    mask = (sz == 4) ? 32'hFFFF_FFFF : (((32'd1 << (8 * sz)) - 32'd1) << sh);
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // Issue one request from a negedge in IDLE and check every cycle until back in IDLE
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    bit          e_err;
    int          lat;
    int          wc;
    logic [31:0] idx;
    logic [31:0] e_word;
    logic [31:0] e_rdata;
    e_err   = m_err(we, f3, addr);
    idx     = addr >> 2;
    e_word  = 32'h0;
    e_rdata = 32'h0;
    if (!e_err && we)  e_word  = m_store(ref_mem[idx[9:0]], wd, f3, addr[1:0]);
    if (!e_err && !we) e_rdata = m_load(ref_mem[idx[9:0]], f3, addr[1:0]);
    lat = e_err ? 1 : ((!we || f3 == 3'd2) ? 2 : 3);
    wc  = (e_err || !we) ? 0 : ((f3 == 3'd2) ? 1 : 2);

    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      // A stray SW while busy must be ignored
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = 32'h0000_0040;
      req_wdata  = $urandom;
      if (c == 1) chk({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
      chk({tag, ".mem_addr"}, mem_addr, idx);
      chk({tag, ".mem_we"}, 32'(mem_we), 32'(c == wc));
      chk({tag, ".mem_wdata"}, mem_wdata, (c == wc) ? e_word : 32'h0);
      chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(c == lat));
      if (c == lat) begin
        chk({tag, ".resp_rdata"}, resp_rdata, e_rdata);
        chk({tag, ".resp_err"}, 32'(resp_err), 32'(e_err));
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, ".idle_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, ".idle_we"}, 32'(mem_we), 32'd0);
    if (!e_err && we) begin
      ref_mem[idx[9:0]] = e_word;
      chk({tag, ".mem_word"}, mem[idx[9:0]], e_word);
    end
  endtask

  task automatic preload(input int i, input logic [31:0] v);
    mem[i]     = v;
    ref_mem[i] = v;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < int'(DEPTH); i++) preload(i, $urandom);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_rdata", resp_rdata, 32'h0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    chk("rst.ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.ready_after", 32'(req_ready), 32'd1);
    @(negedge clk);

    // Directed loads
    preload(7, 32'h0000_0020);
    preload(10, 32'h80FF_7F02);
    do_req("lw_1c", 1'b0, 3'b010, 32'h1C, 32'h0);
    do_req("lb_2b", 1'b0, 3'b000, 32'h2B, 32'h0);
    do_req("lbu_2b", 1'b0, 3'b100, 32'h2B, 32'h0);
    do_req("lh_2a", 1'b0, 3'b001, 32'h2A, 32'h0);
    do_req("lhu_2a", 1'b0, 3'b101, 32'h2A, 32'h0);
    do_req("lb_28", 1'b0, 3'b000, 32'h28, 32'h0);

    // Directed stores including boundaries
    do_req("sb_29", 1'b1, 3'b000, 32'h29, 32'h1234_56AA);
    chk("sb_29.word", mem[10], 32'h80FF_AA02);
    do_req("sh_2a", 1'b1, 3'b001, 32'h2A, 32'h0000_BEEF);
    chk("sh_2a.word", mem[10], 32'hBEEF_AA02);
    do_req("sw_ffc", 1'b1, 3'b010, 32'hFFC, 32'hDEAD_BEEF);
    chk("sw_ffc.word", mem[1023], 32'hDEAD_BEEF);
    do_req("sw_0", 1'b1, 3'b010, 32'h0, 32'h0BAD_F00D);

    // Error requests
    do_req("err_lw_1e", 1'b0, 3'b010, 32'h1E, 32'h0);
    do_req("err_sh_29", 1'b1, 3'b001, 32'h29, 32'h5555);
    do_req("err_sw_1000", 1'b1, 3'b010, 32'h1000, 32'h1111_2222);
    do_req("err_ld_011", 1'b0, 3'b011, 32'h20, 32'h0);
    do_req("err_sb_f3", 1'b1, 3'b100, 32'h20, 32'h77);

    // Reset during the read phase of a sub-word store
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 32'h29;
    req_wdata  = 32'h0000_0033;
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    #1;
    chk("rstmid.mem_we_rd", 32'(mem_we), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid.ready", 32'(req_ready), 32'd1);
    chk("rstmid.resp_valid", 32'(resp_valid), 32'd0);
    chk("rstmid.mem_we", 32'(mem_we), 32'd0);
    chk("rstmid.mem_addr", mem_addr, 32'h0);
    chk("rstmid.word", mem[10], ref_mem[10]);
    do_req("rstmid.lw", 1'b0, 3'b010, 32'h28, 32'h0);

    // Random requests against the model
    for (int n = 0; n < 120; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] idx;
      logic [31:0] addr;
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      idx  = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(1020, 1027))
                                         : 32'($urandom_range(0, 15));
      addr = (idx << 2) | 32'($urandom_range(0, 3));
      do_req("rand", we, f3, addr, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
